// File: rtl/pool_pkg.sv
// Shared definitions for the pooling reduction path: mode codes, FSM
// encoding and a configuration sanity helper.
package pool_pkg;

  localparam int DWIDTH_DEF = 8;

  localparam logic POOL_MODE_MAX = 1'b0;
  localparam logic POOL_MODE_AVG = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } pool_state_e;

  // True when size is a power of two in 2..16 and matches its log2.
  function automatic logic pool_cfg_ok(input int size, input int log2_size);
    logic ok;
    ok = 1'b0;
    if ((size >= 2) && (size <= 16) && (log2_size >= 1) && (size == (1 << log2_size))) begin
      ok = 1'b1;
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/pool_alu.sv
// Combinational datapath for one pooling step: folds a new sample into the
// running max/sum and produces the pooled result from the updated value.
module pool_alu
  import pool_pkg::*;
#(
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int LOG2_POOL = 2
) (
  input  logic                            mode_i,
  input  logic                            first_i,
  input  logic [2*DWIDTH+LOG2_POOL-1:0]   acc_i,
  input  logic [2*DWIDTH-1:0]             sample_i,
  output logic [2*DWIDTH+LOG2_POOL-1:0]   acc_next_o,
  output logic [2*DWIDTH-1:0]             result_o
);

  localparam int SW = 2 * DWIDTH;
  localparam int AW = SW + LOG2_POOL;

  logic signed [AW-1:0] sample_ext;
  logic signed [AW-1:0] acc_cur;
  logic signed [AW-1:0] acc_nxt;
  logic signed [AW-1:0] acc_shr;

  // Max mode keeps the running maximum sign-extended in the accumulator so
  // both modes share one register and one signed compare width.
  always_comb begin
    sample_ext = {{LOG2_POOL{sample_i[SW-1]}}, sample_i};
    acc_cur    = acc_i;
    acc_nxt    = acc_cur;
    acc_shr    = '0;
    result_o   = '0;
    if (first_i) begin
      acc_nxt = sample_ext;
    end else if (mode_i == POOL_MODE_AVG) begin
      acc_nxt = acc_cur + sample_ext;
    end else if (sample_ext > acc_cur) begin
      acc_nxt = sample_ext;
    end else begin
      acc_nxt = acc_cur;
    end

    if (mode_i == POOL_MODE_AVG) begin
      acc_shr  = acc_nxt >>> LOG2_POOL;
      result_o = acc_shr[SW-1:0];
    end else begin
      acc_shr  = acc_nxt;
      result_o = acc_nxt[SW-1:0];
    end
    acc_next_o = acc_nxt;
  end

endmodule

// File: rtl/pool_window_reducer.sv
// Streaming max/average reducer: collects POOL_SIZE samples over valid/ready
// and emits one registered pooled result per window.
module pool_window_reducer
  import pool_pkg::*;
#(
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int POOL_SIZE = 4,
  parameter int LOG2_POOL = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pool_mode,
  input  logic [2*DWIDTH-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [2*DWIDTH-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int SW = 2 * DWIDTH;
  localparam int AW = SW + LOG2_POOL;
  localparam logic [LOG2_POOL-1:0] LAST_IDX = LOG2_POOL'(POOL_SIZE - 1);

  if (!pool_cfg_ok(POOL_SIZE, LOG2_POOL)) begin : g_bad_cfg
    $error("pool_window_reducer: POOL_SIZE must be 2..16, a power of two, equal to 2**LOG2_POOL");
  end

  pool_state_e          state_q;
  logic [LOG2_POOL-1:0] count_q;
  logic [AW-1:0]        acc_q;
  logic [AW-1:0]        acc_d;
  logic [SW-1:0]        result_d;
  logic                 mode_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [SW-1:0]        out_data_q;

  logic accept;
  logic first_sample;
  logic alu_mode;

  assign accept       = in_valid & in_ready_q;
  assign first_sample = (state_q == IDLE);
  // The window's mode is latched on its first sample; later flips are ignored.
  assign alu_mode     = first_sample ? pool_mode : mode_q;

  pool_alu #(
    .DWIDTH    (DWIDTH),
    .LOG2_POOL (LOG2_POOL)
  ) u_alu (
    .mode_i     (alu_mode),
    .first_i    (first_sample),
    .acc_i      (acc_q),
    .sample_i   (in_data),
    .acc_next_o (acc_d),
    .result_o   (result_d)
  );

  // Window FSM with sample counter, accumulator and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      mode_q      <= POOL_MODE_MAX;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          if (accept) begin
            mode_q  <= pool_mode;
            acc_q   <= acc_d;
            count_q <= LOG2_POOL'(1);
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            acc_q <= acc_d;
            if (count_q == LAST_IDX) begin
              state_q     <= DONE;
              count_q     <= '0;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= result_d;
            end else begin
              count_q <= count_q + LOG2_POOL'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          count_q     <= '0;
          acc_q       <= '0;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_pool_window_reducer.sv
// Directed self-checking bench for pool_window_reducer (DWIDTH=8, POOL_SIZE=4).
module tb_pool_window_reducer;

  logic        clk;
  logic        reset;
  logic        pool_mode;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int n_checks;
  int n_fail;

  pool_window_reducer #(
    .DWIDTH    (8),
    .POOL_SIZE (4),
    .LOG2_POOL (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pool_mode (pool_mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one sample at a negedge, wait (bounded) for in_ready, let one
  // posedge accept it and return at the following negedge with in_valid low.
  task automatic drive_sample(input logic [15:0] d, input logic m);
    int guard;
    guard     = 0;
    in_valid  = 1'b1;
    in_data   = d;
    pool_mode = m;
    while ((in_ready !== 1'b1) && (guard < 20)) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready=%b required 1 within 20 cycles", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 16'h0000; pool_mode = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: in_ready/out_valid/busy=%b required 000", {in_ready, out_valid, busy});
    end
    n_checks++;
    if (out_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_data: out_data=%h required 0000", out_data);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_ready, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL post_reset: in_ready/busy=%b required 10", {in_ready, busy});
    end
  endtask

  task automatic test_max();
    out_ready = 1'b1;
    drive_sample(16'h0010, 1'b0);
    drive_sample(16'hFFF0, 1'b0);
    drive_sample(16'h0200, 1'b0);
    n_checks++;
    if ({in_ready, busy, out_valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL max_collect: in_ready/busy/out_valid=%b required 110", {in_ready, busy, out_valid});
    end
    drive_sample(16'h0100, 1'b0);
    n_checks++;
    if ({out_valid, in_ready, busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL max_done_flags: out_valid/in_ready/busy=%b required 101", {out_valid, in_ready, busy});
    end
    n_checks++;
    if (out_data !== 16'h0200) begin
      n_fail++;
      $display("FAIL max_data: out_data=%h required 0200", out_data);
    end
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL max_return: out_valid/in_ready/busy=%b required 010", {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_avg();
    out_ready = 1'b1;
    drive_sample(16'h0004, 1'b1);
    drive_sample(16'h0008, 1'b1);
    drive_sample(16'h000C, 1'b1);
    drive_sample(16'h0010, 1'b1);
    n_checks++;
    if ((out_valid !== 1'b1) || (out_data !== 16'h000A)) begin
      n_fail++;
      $display("FAIL avg_pos: out_valid=%b out_data=%h required 1/000a", out_valid, out_data);
    end
    @(negedge clk);
    drive_sample(16'hFFFF, 1'b1);
    drive_sample(16'hFFFF, 1'b1);
    drive_sample(16'hFFFF, 1'b1);
    drive_sample(16'h0000, 1'b1);
    n_checks++;
    if ((out_valid !== 1'b1) || (out_data !== 16'hFFFF)) begin
      n_fail++;
      $display("FAIL avg_floor: out_valid=%b out_data=%h required 1/ffff", out_valid, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_extreme_avg();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive_sample(16'h7FFF, 1'b1);
    n_checks++;
    if ((out_valid !== 1'b1) || (out_data !== 16'h7FFF)) begin
      n_fail++;
      $display("FAIL avg_max_pos: out_valid=%b out_data=%h required 1/7fff", out_valid, out_data);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) drive_sample(16'h8000, 1'b1);
    n_checks++;
    if ((out_valid !== 1'b1) || (out_data !== 16'h8000)) begin
      n_fail++;
      $display("FAIL avg_max_neg: out_valid=%b out_data=%h required 1/8000", out_valid, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int bad;
    out_ready = 1'b0;
    drive_sample(16'h0005, 1'b0);
    drive_sample(16'h0006, 1'b0);
    drive_sample(16'h0008, 1'b0);
    drive_sample(16'h0007, 1'b0);
    bad = 0;
    in_valid = 1'b1;
    in_data  = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      if ((out_valid !== 1'b1) || (out_data !== 16'h0008) || (in_ready !== 1'b0)) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d unstable cycles required 0 (out_valid=%b out_data=%h in_ready=%b)",
               bad, out_valid, out_data, in_ready);
    end
    in_data   = 16'h7777;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL bp_release: out_valid/busy/in_ready=%b required 001", {out_valid, busy, in_ready});
    end
    for (int i = 0; i < 4; i++) drive_sample(16'h0010, 1'b1);
    n_checks++;
    if ((out_valid !== 1'b1) || (out_data !== 16'h0010)) begin
      n_fail++;
      $display("FAIL bp_next_window: out_valid=%b out_data=%h required 1/0010", out_valid, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_mode_change();
    out_ready = 1'b1;
    drive_sample(16'h0001, 1'b0);
    drive_sample(16'h0009, 1'b0);
    drive_sample(16'h0003, 1'b1);
    drive_sample(16'h0002, 1'b1);
    n_checks++;
    if ((out_valid !== 1'b1) || (out_data !== 16'h0009)) begin
      n_fail++;
      $display("FAIL mode_latch: out_valid=%b out_data=%h required 1/0009", out_valid, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive_sample(16'h0002, 1'b1);
    n_checks++;
    if ((out_valid !== 1'b1) || (out_data !== 16'h0002)) begin
      n_fail++;
      $display("FAIL b2b_first: out_valid=%b out_data=%h required 1/0002", out_valid, out_data);
    end
    drive_sample(16'hFFF0, 1'b0);
    drive_sample(16'h0003, 1'b0);
    drive_sample(16'hFFFF, 1'b0);
    drive_sample(16'h0001, 1'b0);
    n_checks++;
    if ((out_valid !== 1'b1) || (out_data !== 16'h0003)) begin
      n_fail++;
      $display("FAIL b2b_signed_max: out_valid=%b out_data=%h required 1/0003", out_valid, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive_sample(16'h0050, 1'b0);
    drive_sample(16'h0060, 1'b0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: busy=%b required 1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_reset: busy/out_valid=%b required 00", {busy, out_valid});
    end
    reset = 1'b0;
    drive_sample(16'h0001, 1'b0);
    drive_sample(16'h0002, 1'b0);
    drive_sample(16'h0003, 1'b0);
    drive_sample(16'h0004, 1'b0);
    n_checks++;
    if ((out_valid !== 1'b1) || (out_data !== 16'h0004)) begin
      n_fail++;
      $display("FAIL mid_new_window: out_valid=%b out_data=%h required 1/0004", out_valid, out_data);
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_max();
    test_avg();
    test_extreme_avg();
    test_backpressure();
    test_mode_change();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pool_window_reducer.md
Name: pool_window_reducer

Overview:
- Streaming reduction block for the pooling path.
- Collects POOL_SIZE signed fixed-point samples, the same 2*DWIDTH format produced by qadd, from an upstream valid/ready stream.
- Emits one pooled result per window, either the maximum or the average (sum shifted right), on a downstream valid/ready stream.
- Sits between the systolic-array output drain and the pooling writeback.

Parameters:
- DWIDTH, 8, base data width; samples and results are 2*DWIDTH bits, signed two's complement.
- POOL_SIZE, 4, samples per window; must be a power of 2 in the range 2..16.
- LOG2_POOL, 2, log2(POOL_SIZE); must be consistent with POOL_SIZE (checked by an elaboration assertion).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pool_mode  in  1  0 = max pooling, 1 = average pooling; sampled with the first sample of each window.
- in_data  in  2*DWIDTH  signed input sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a sample.
- out_data  out  2*DWIDTH  signed pooled result.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  high when a window is partially collected or a result is pending.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, sample count=0, accumulator=0, state=IDLE.
- States and transitions:
  - IDLE: entered from reset. in_ready=1 from the first cycle after reset deasserts. Go to COLLECT on the first accepted sample.
  - COLLECT: in_ready=1. Each accepted sample increments the count.
  - COLLECT → DONE: when the POOL_SIZE-th sample is accepted.
  - DONE: in_ready=0, out_valid=1, out_data stable. Go to IDLE on (out_valid & out_ready).
- Accept condition: a sample is accepted on (in_valid & in_ready) at a clock edge.
- Window start: the first accepted sample stores pool_mode into a mode register. pool_mode changes mid-window are ignored.
- Max mode:
  - max_reg is loaded with the first sample.
  - Each later sample replaces max_reg if it is greater, using a signed compare.
  - On a tie, max_reg is kept.
- Avg mode:
  - The accumulator is 2*DWIDTH+LOG2_POOL bits, signed.
  - The first sample loads the accumulator sign-extended; later samples add sign-extended.
  - There is no overflow inside the window.
  - Result = accumulator >>> LOG2_POOL (arithmetic shift, truncation toward negative infinity). The result always fits in 2*DWIDTH bits, so no saturation is needed.
- Latency: out_valid rises on the cycle after the edge that accepts the last sample. out_data is registered at that edge.
- Throughput: one sample per cycle in COLLECT. One bubble cycle per window (DONE plus the return to IDLE). The block makes no back-to-back window overlap.
- Backpressure:
  - out_data and out_valid hold indefinitely while out_ready=0.
  - in_valid without in_ready has no effect.
  - out_ready while out_valid=0 is ignored.
- busy = (state != IDLE).
- Reset mid-window or mid-DONE:
  - Partial data and any pending result are discarded; there is no flush.
  - On the cycle after reset deasserts, the next accepted sample starts a new window.
- Simultaneous in_valid and out_ready in DONE: only the output handshake completes. The input is not accepted because in_ready=0.

Decomposition:
- Shared package pool_pkg holds:
  - DWIDTH default;
  - POOL_MODE_MAX=0 and POOL_MODE_AVG=1 constants;
  - state encoding: IDLE=2'd0, COLLECT=2'd1, DONE=2'd2.
- One natural sub-module: pool_alu, combinational.
  - Inputs: mode, current accumulator/max, new sample.
  - Outputs: the next accumulator/max value and the final shifted result.
- FSM, counter and handshake stay in the top module.

Test Plan:
- Max, POOL_SIZE=4, samples 0x0010, 0xFFF0, 0x0200, 0x0100 with continuous valid and out_ready=1 → out_data=0x0200. out_valid rises 1 cycle after the 4th accept. in_ready=0 during the DONE cycle.
- Avg, samples 0x0004, 0x0008, 0x000C, 0x0010 → sum 0x28, out_data=0x000A. Then samples 0xFFFF ×3 plus 0x0000 → sum -3, out_data=0xFFFF (floor).
- Extreme avg: four samples of 0x7FFF → 0x7FFF. Four samples of 0x8000 → 0x8000. No wrap in either case.
- Backpressure: out_ready=0 for 5 cycles after out_valid → out_data and out_valid stable and in_ready=0 throughout. Assert out_ready → one handshake, and the next window starts cleanly.
- Mode change mid-window: pool_mode=MAX on the first sample, flipped to AVG after 2 samples, samples 1, 9, 3, 2 → out_data=9.
- Reset after 2 of 4 samples → busy=0 and out_valid=0 next cycle. The next 4 samples 0x0001, 0x0002, 0x0003, 0x0004 in max mode → out_data=0x0004.
